// File: rtl/pipe_pkg.sv
// Shared definitions for the registered N:1 operand mux: default lane width
// and the select-width helper.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Never returns 0, so a single-lane instance still gets a 1-bit select.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_comb.sv
// Combinational NUM_IN:1 lane select with range check; out-of-range codes
// return zero data and raise err.
module muxn_comb
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] lanes,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        data = '0;
        err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = lanes[i*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_muxn.sv
// Registered N:1 operand mux behind a valid/ready handshake; a one-entry skid
// buffer lets in_ready come straight from a flop.
module pipe_muxn
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } entry_t;

    entry_t           new_entry;
    entry_t           main_q;
    entry_t           skid_q;
    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             pop;

    muxn_comb #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN)
    ) u_mux (
        .lanes(in_data),
        .sel  (sel),
        .data (sel_data),
        .err  (sel_err)
    );

    assign new_entry = '{data: sel_data, err: sel_err};
    assign accept    = in_valid & in_ready;
    assign pop       = main_v & out_ready;

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q.data;
    assign out_err   = main_q.err;

    // NOTE: non-blocking assignments keep every flop reading pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (pop) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (!main_v) begin
            if (accept) begin
                main_q <= new_entry;
                main_v <= 1'b1;
            end
        end else begin
            // Main is occupied: a pop frees it for the new entry, otherwise spill to skid.
            unique case ({accept, pop})
                2'b11: main_q <= new_entry;
                2'b10: begin
                    skid_q <= new_entry;
                    skid_v <= 1'b1;
                end
                2'b01: main_v <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pipe_muxn.md
Name: pipe_muxn

Overview:
Parametrised successor to the 4:1 32-bit operand mux.
- Selects one of NUM_IN lanes of WIDTH bits.
- Registers the result behind a valid/ready handshake, with a one-entry skid buffer so in_ready is driven purely from a flop.
- Used between EX-stage operand selection and downstream consumers that can stall; supports pipeline flush.

Parameters:
- WIDTH, 32, data width per lane.
- NUM_IN, 4, number of input lanes (2..16).
- SEL_W, $clog2(NUM_IN), select width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered entries.
- in_data  input  NUM_IN*WIDTH  flattened lanes; lane i = in_data[i*WIDTH +: WIDTH].
- sel  input  SEL_W  lane select, sampled on accept.
- in_valid  input  1  upstream has a request.
- in_ready  output  1  block can accept (registered).
- out_data  output  WIDTH  selected lane, registered.
- out_err  output  1  entry was captured with sel >= NUM_IN.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Storage: a main register (main_v, main_d, main_e) and a skid register (skid_v, skid_d, skid_e).
- Accept: accept = in_valid & in_ready. Captured value is lane[sel] if sel < NUM_IN, else all-zero data with err=1.
- Outputs: out_valid = main_v, out_data = main_d, out_err = main_e, in_ready = ~skid_v.
  - Only in_ready's source flop (skid_v) drives in_ready; there is no combinational path from out_ready.
- Pop: pop = main_v & out_ready.
- Latency: an accepted value appears on out_* the cycle after acceptance if main is empty or popping.
- Next-state rules (evaluated each posedge, priority top-down):
  1. rst: main_v=0, skid_v=0, main_d=0, main_e=0, skid_d=0, skid_e=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_err=0.
  2. flush: main_v=0, skid_v=0; data regs may hold. An accept in the same cycle is dropped. A pop in the same cycle still counts as consumed downstream.
  3. skid_v=1 (in_ready=0, no accept possible): if pop, main<=skid and skid_v<=0; else hold.
  4. skid_v=0, main_v=0: if accept, main<=new.
  5. skid_v=0, main_v=1:
     - accept & pop: main<=new.
     - accept & ~pop: skid<=new, skid_v<=1.
     - ~accept & pop: main_v<=0.
     - neither: hold.
- Ordering: strict FIFO; at most 2 entries in flight. No entry is lost or duplicated except by flush or rst.
- Full/back-pressure: with out_ready held 0, exactly two accepts succeed, then in_ready=0.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- sel is only meaningful when in_valid=1. in_data and sel are not held internally before accept.
- Reset mid-operation discards everything, identical to power-on reset.
- NUM_IN not a power of two: codes NUM_IN..2^SEL_W-1 are error codes. For NUM_IN a power of two, out_err is constant 0.

Decomposition:
- Shared package pipe_pkg:
  - localparam default data width (32).
  - Function clog2_min1 (returns >=1 so NUM_IN=1 never yields a zero-width sel).
  - Typedef of the entry struct {data, err} parametrised via WIDTH in-module.
- One natural sub-module: muxn_comb (parametrised combinational NUM_IN:1 lane select plus range check producing {data, err}). It is the generalisation of the existing 4:1 mux.
- Handshake and skid logic live in pipe_muxn.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_err=0, in_ready=1 during and after reset; nothing accepted.
- Basic select, NUM_IN=4, out_ready=1: lanes = 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel=2,0,3 on consecutive cycles -> out_data = 0x33333333, 0x11111111, 0x44444444 one cycle after each accept, out_valid continuous.
- Back-pressure: out_ready=0, present A=0xA0, B=0xB0, C=0xC0 -> A and B accepted, in_ready=0 from the cycle after B. Raise out_ready -> outputs A, B, then C, in order, no duplicates.
- Flush: two entries buffered, pulse flush with in_valid=1 (data 0xDD) -> next cycle out_valid=0, in_ready=1, and 0xDD is never output.
- Error select, NUM_IN=3, SEL_W=2: sel=3 -> out_data=0, out_err=1. Following sel=1 -> lane1 data, out_err=0.
- Random soak: 10k cycles of random in_valid/out_ready/sel/flush against a 2-deep reference-queue scoreboard -> no mismatch; in_ready never depends combinationally on out_ready.
